// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: measures high-pulse widths, decodes MSB-first
// 24-bit pixels onto a valid/ready output and flags latch gaps as frame ends.
module ws2812b_rx #(
    parameter int CLOCK_MHZ  = 64,
    parameter int THRESH_NS  = 600,
    parameter int GLITCH_NS  = 100,
    parameter int MAXHIGH_NS = 5000,
    parameter int LATCH_US   = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        valid,
    input  logic        ready,
    output logic        frame_end,
    output logic [3:0]  err,
    input  logic        clear_err
);

    localparam logic [15:0] THRESH_CYC  = 16'(CLOCK_MHZ * THRESH_NS / 1000);
    localparam logic [15:0] GLITCH_CYC  = 16'(CLOCK_MHZ * GLITCH_NS / 1000);
    localparam logic [15:0] MAXHIGH_CYC = 16'(CLOCK_MHZ * MAXHIGH_NS / 1000);
    localparam logic [15:0] LATCH_CYC   = 16'(CLOCK_MHZ * LATCH_US);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

    state_t      state, next_state;
    logic        din_meta, s, s_prev;
    logic        rise, fall;
    logic [15:0] hi_cnt, lo_cnt;
    logic [23:0] sr;
    logic [4:0]  bitcnt;
    logic        armed;
    logic        pend;
    logic        hi_load, hi_inc, lo_load, lo_inc;
    logic        eval, stuck_hit, frame_chk;
    logic        glitch, bit_val;
    logic [3:0]  err_set;

    assign rise    = s & ~s_prev;
    assign fall    = ~s & s_prev;
    assign glitch  = hi_cnt < GLITCH_CYC;
    assign bit_val = hi_cnt >= THRESH_CYC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta <= 1'b0;
            s        <= 1'b0;
            s_prev   <= 1'b0;
            state    <= IDLE;
        end else begin
            din_meta <= din;
            s        <= din_meta;
            s_prev   <= s;
            state    <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        hi_load    = 1'b0;
        hi_inc     = 1'b0;
        lo_load    = 1'b0;
        lo_inc     = 1'b0;
        eval       = 1'b0;
        stuck_hit  = 1'b0;
        frame_chk  = 1'b0;
        case (state)
            IDLE: begin
                lo_inc = 1'b1;
                if (rise) begin
                    hi_load    = 1'b1;
                    next_state = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    eval       = 1'b1;
                    lo_load    = 1'b1;
                    next_state = LOW;
                end else if (hi_cnt > MAXHIGH_CYC) begin
                    stuck_hit  = 1'b1;
                    next_state = STUCK;
                end else begin
                    hi_inc = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    hi_load    = 1'b1;
                    next_state = HIGH;
                end else if (lo_cnt == LATCH_CYC) begin
                    frame_chk  = 1'b1;
                    next_state = IDLE;
                end else begin
                    lo_inc = 1'b1;
                end
            end
            STUCK: begin
                // The stuck pulse itself never decodes into a bit.
                if (fall) begin
                    lo_load    = 1'b1;
                    next_state = LOW;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        err_set    = 4'b0000;
        err_set[0] = eval && glitch;
        err_set[1] = stuck_hit;
        err_set[2] = pend && valid && !ready;
        err_set[3] = frame_chk && armed && (bitcnt != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt    <= 16'd0;
            lo_cnt    <= 16'd0;
            sr        <= 24'd0;
            bitcnt    <= 5'd0;
            armed     <= 1'b0;
            pend      <= 1'b0;
            data_out  <= 24'd0;
            valid     <= 1'b0;
            frame_end <= 1'b0;
            err       <= 4'b0000;
        end else begin
            if (hi_load)
                hi_cnt <= 16'd1;
            else if (hi_inc && hi_cnt != 16'hFFFF)
                hi_cnt <= hi_cnt + 16'd1;

            if (lo_load)
                lo_cnt <= 16'd1;
            else if (lo_inc && lo_cnt != 16'hFFFF)
                lo_cnt <= lo_cnt + 16'd1;

            pend      <= 1'b0;
            frame_end <= 1'b0;
            // A set in the same cycle as clear_err survives the clear.
            err       <= (clear_err ? 4'b0000 : err) | err_set;

            if (eval && !glitch) begin
                sr    <= {sr[22:0], bit_val};
                armed <= 1'b1;
                if (bitcnt == 5'd23) begin
                    pend   <= 1'b1;
                    bitcnt <= 5'd0;
                end else begin
                    bitcnt <= bitcnt + 5'd1;
                end
            end

            if (stuck_hit)
                bitcnt <= 5'd0;

            if (frame_chk && armed) begin
                frame_end <= 1'b1;
                armed     <= 1'b0;
                bitcnt    <= 5'd0;
            end

            // sr still holds the completed pixel: no bit can arrive one cycle after a fall.
            if (pend && !(valid && !ready)) begin
                data_out <= sr;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: pixel decode, handshake, frame gaps, error flags, reset.
module tb_ws2812b_rx;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic [23:0] data_out;
    logic        valid;
    logic        ready;
    logic        frame_end;
    logic [3:0]  err;
    logic        clear_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int fe_cyc   = 0;
    int fe_count = 0;
    int valid_cycles = 0;

    logic [23:0] acc_q[$];
    logic [23:0] exp_q[$];

    ws2812b_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .frame_end (frame_end),
        .err       (err),
        .clear_err (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor samples 1 time unit after the falling edge, once inputs have settled.
    always @(negedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rst_n) begin
            if (valid) valid_cycles = valid_cycles + 1;
            if (valid && ready) acc_q.push_back(data_out);
            if (frame_end) begin
                fe_count = fe_count + 1;
                fe_cyc   = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
        while (acc_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_data"}, {8'h00, acc_q.pop_front()}, {8'h00, exp_q.pop_front()});
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic hold(input logic level, input int n);
        din = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        hold(1'b1, b ? 51 : 25);
        din      = 1'b0;
        fall_cyc = cyc;
        repeat (b ? 29 : 55) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] px, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) send_bit(px[i]);
    endtask

    task automatic pulse_clear;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] px;
        rst_n     = 1'b0;
        din       = 1'b0;
        ready     = 1'b0;
        clear_err = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data", {8'h00, data_out}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frame_end", {31'd0, frame_end}, 32'd0);
        check("rst_err", {28'd0, err}, 32'd0);
        rst_n = 1'b1;

        // Idle-low line after reset must not report a frame end.
        hold(1'b0, 4000);
        check("idle_no_frame", 32'(fe_count), 32'd0);

        // Single pixel, consumer always ready.
        ready = 1'b1;
        valid_cycles = 0;
        fe_count = 0;
        exp_q.push_back(24'hFF0080);
        send_bits(24'hFF0080, 24);
        hold(1'b0, 10);
        drain("t1");
        check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
        check("t1_err", {28'd0, err}, 32'd0);

        // Long low gap after the pixel: one frame end ~3200 cycles after the last fall.
        hold(1'b0, 20800 - 65);
        check("t2_frame_count", 32'(fe_count), 32'd1);
        check("t2_latency", {31'd0, (fe_cyc - fall_cyc >= 3200) && (fe_cyc - fall_cyc <= 3210)}, 32'd1);
        check("t2_err", {28'd0, err}, 32'd0);

        // Overrun: two pixels while the consumer stalls.
        ready = 1'b0;
        send_bits(24'h123456, 24);
        send_bits(24'hABCDEF, 24);
        hold(1'b0, 10);
        check("t3_valid_held", {31'd0, valid}, 32'd1);
        check("t3_data_held", {8'h00, data_out}, 32'h123456);
        check("t3_err_overrun", {28'd0, err}, 32'h4);
        exp_q.push_back(24'h123456);
        ready = 1'b1;
        hold(1'b0, 5);
        drain("t3");
        check("t3_valid_drop", {31'd0, valid}, 32'd0);
        hold(1'b0, 3400);
        pulse_clear();
        check("t3_err_clear", {28'd0, err}, 32'd0);

        // Glitch between bits 5 and 6 is ignored but flagged.
        px = 24'h00FF00;
        exp_q.push_back(px);
        for (int i = 23; i >= 0; i--) begin
            send_bit(px[i]);
            if (i == 19) begin
                hold(1'b1, 3);
                hold(1'b0, 30);
            end
        end
        hold(1'b0, 10);
        drain("t4");
        check("t4_err_glitch", {28'd0, err}, 32'h1);
        hold(1'b0, 3400);
        pulse_clear();

        // Stuck-high line then a partial pixel closed by a latch gap.
        fe_count = 0;
        valid_cycles = 0;
        hold(1'b1, 400);
        hold(1'b0, 40);
        send_bits(24'hA5A5A5, 10);
        hold(1'b0, 3400);
        check("t5_err", {28'd0, err}, 32'hA);
        check("t5_frame_count", 32'(fe_count), 32'd1);
        check("t5_no_valid", 32'(valid_cycles), 32'd0);
        drain("t5");
        pulse_clear();
        check("t5_err_clear", {28'd0, err}, 32'd0);

        // Reset in the middle of a pixel discards all partial state.
        send_bits(24'hFFF000, 12);
        hold(1'b1, 20);
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_rst_valid", {31'd0, valid}, 32'd0);
        rst_n = 1'b1;
        hold(1'b0, 40);
        exp_q.push_back(24'h0000FF);
        send_bits(24'h0000FF, 24);
        hold(1'b0, 10);
        drain("t6");
        check("t6_err", {28'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
